// File: rtl/mag_compare_serial.sv
// Digit-serial magnitude comparator: DIGIT bits per cycle, MSB digit first, unsigned or two's complement.
// Latency: k cycles from the start edge to done; k = first differing digit + 1 (EARLY_EXIT=1) or NDIG.
// Backpressure: none; start is accepted in IDLE or DONE and ignored while busy.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               request a compare (accepted in IDLE or DONE)
//   signed_mode, a, b   operands and mode, sampled with an accepted start
//   busy                compare in progress (state RUN)
//   done                one-cycle pulse; y_e/y_g/y_l/cnt valid from here on
//   y_e, y_g, y_l       one-hot result: a==b, a>b, a<b (held until the next compare finishes)
//   cnt                 digits examined by the last compare
module mag_compare_serial #(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter int EARLY_EXIT = 1,
  localparam int NDIG      = WIDTH / DIGIT,
  localparam int CW        = $clog2(NDIG) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             y_e,
  output logic             y_g,
  output logic             y_l,
  output logic [CW-1:0]    cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0]    idx;
  logic             rec_vld;   // a difference has already been seen in this compare
  logic             rec_g;     // direction of that first difference

  logic [DIGIT-1:0] dig_a, dig_b;
  logic             diff, gt, last, early;
  logic             load, step, fin;
  logic             res_e, res_g, res_l;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] msb_flip;

  // Flipping the sign bit maps two's complement onto offset binary,
  // so the same unsigned digit compare serves both modes.
  assign msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};

  assign dig_a = sh_a[WIDTH-1 -: DIGIT];
  assign dig_b = sh_b[WIDTH-1 -: DIGIT];
  assign diff  = (dig_a != dig_b);
  assign gt    = (dig_a > dig_b);
  assign last  = (idx == CW'(NDIG - 1));
  assign early = (EARLY_EXIT != 0) && diff;

  // An earlier recorded difference outranks the current digit; only the
  // EARLY_EXIT=0 path can reach a finish with rec_vld set.
  assign res_g   = rec_vld ? rec_g  : (diff & gt);
  assign res_l   = rec_vld ? ~rec_g : (diff & ~gt);
  assign res_e   = ~rec_vld & ~diff;
  assign cnt_nxt = early ? (idx + CW'(1)) : CW'(NDIG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (last || early) begin
          fin       = 1'b1;
          state_nxt = S_DONE;
        end else begin
          step      = 1'b1;
        end
      end
      S_DONE: begin
        load      = start;
        state_nxt = start ? S_RUN : S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand shifters and difference tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a    <= '0;
      sh_b    <= '0;
      idx     <= '0;
      rec_vld <= 1'b0;
      rec_g   <= 1'b0;
    end else if (load) begin
      sh_a    <= a ^ msb_flip;
      sh_b    <= b ^ msb_flip;
      idx     <= '0;
      rec_vld <= 1'b0;
      rec_g   <= 1'b0;
    end else if (step) begin
      sh_a <= sh_a << DIGIT;
      sh_b <= sh_b << DIGIT;
      idx  <= idx + CW'(1);
      if (diff && !rec_vld) begin
        rec_vld <= 1'b1;
        rec_g   <= gt;
      end
    end
  end

  // Result registers only change on completion, so they hold through the next compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_e <= 1'b0;
      y_g <= 1'b0;
      y_l <= 1'b0;
      cnt <= '0;
    end else if (fin) begin
      y_e <= res_e;
      y_g <= res_g;
      y_l <= res_l;
      cnt <= cnt_nxt;
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_mag_compare_serial.sv
module tb_mag_compare_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        signed_mode;
  logic [15:0] op_a, op_b;

  logic       busy_ee, done_ee, ye_ee, yg_ee, yl_ee;
  logic       busy_ct, done_ct, ye_ct, yg_ct, yl_ct;
  logic [2:0] cnt_ee, cnt_ct;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    string      tag;
    logic [2:0] flags;   // {e,g,l}
    logic [2:0] cnt;
    int         lat;
    int         t0;
  } exp_t;

  exp_t q_ee[$];
  exp_t q_ct[$];
  exp_t x_ee, x_ct;
  int   bc_ee = 0;
  int   bc_ct = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mag_compare_serial #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) u_ee (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(op_a), .b(op_b), .busy(busy_ee), .done(done_ee),
    .y_e(ye_ee), .y_g(yg_ee), .y_l(yl_ee), .cnt(cnt_ee)
  );

  mag_compare_serial #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) u_ct (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(op_a), .b(op_b), .busy(busy_ct), .done(done_ct),
    .y_e(ye_ct), .y_g(yg_ct), .y_l(yl_ct), .cnt(cnt_ct)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic score(input string inst, input exp_t x, input logic [2:0] flags,
                       input logic [2:0] c, input int bc);
    check({inst, "_", x.tag, "_flags"}, 32'(flags), 32'(x.flags));
    check({inst, "_", x.tag, "_cnt"},   32'(c),     32'(x.cnt));
    check({inst, "_", x.tag, "_lat"},   32'(cyc - x.t0), 32'(x.lat));
    check({inst, "_", x.tag, "_busy"},  32'(bc),    32'(x.lat));
  endtask

  // Scoreboard monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      bc_ee = 0;
    end else begin
      if (busy_ee) bc_ee++;
      if (done_ee) begin
        if (q_ee.size() == 0) check("ee_unexpected_done", 32'd1, 32'd0);
        else begin
          x_ee = q_ee.pop_front();
          score("ee", x_ee, {ye_ee, yg_ee, yl_ee}, cnt_ee, bc_ee);
        end
        bc_ee = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      bc_ct = 0;
    end else begin
      if (busy_ct) bc_ct++;
      if (done_ct) begin
        if (q_ct.size() == 0) check("ct_unexpected_done", 32'd1, 32'd0);
        else begin
          x_ct = q_ct.pop_front();
          score("ct", x_ct, {ye_ct, yg_ct, yl_ct}, cnt_ct, bc_ct);
        end
        bc_ct = 0;
      end
    end
  end

  // Push expectations for both instances; the constant-time one always takes 4 cycles.
  task automatic expect_res(input string tag, input logic [2:0] flags, input int k_ee);
    exp_t e;
    e.tag   = tag;
    e.flags = flags;
    e.t0    = cyc + 1;
    e.lat   = k_ee;
    e.cnt   = 3'(k_ee);
    q_ee.push_back(e);
    e.lat   = 4;
    e.cnt   = 3'd4;
    q_ct.push_back(e);
  endtask

  // Called just after a falling edge; the following rising edge samples start.
  task automatic go(input logic [15:0] va, input logic [15:0] vb, input logic sm);
    op_a        = va;
    op_b        = vb;
    signed_mode = sm;
    start       = 1'b1;
    @(negedge clk); #1;
    start       = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((q_ee.size() != 0 || q_ct.size() != 0) && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_drain_timeout"}, 32'(q_ee.size() + q_ct.size()), 32'd0);
  endtask

  task automatic run(input string tag, input logic [15:0] va, input logic [15:0] vb,
                     input logic sm, input logic [2:0] flags, input int k_ee);
    @(negedge clk); #1;
    expect_res(tag, flags, k_ee);
    go(va, vb, sm);
    drain(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    op_a        = '0;
    op_b        = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ee", 32'({busy_ee, done_ee, ye_ee, yg_ee, yl_ee, cnt_ee}), 32'd0);
    check("reset_ct", 32'({busy_ct, done_ct, ye_ct, yg_ct, yl_ct, cnt_ct}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // {e,g,l} flags, early-exit latency
    run("eq",        16'h1234, 16'h1234, 1'b0, 3'b100, 4);
    run("top_uns",   16'h8000, 16'h7FFF, 1'b0, 3'b010, 1);
    run("top_sgn",   16'h8000, 16'h7FFF, 1'b1, 3'b001, 1);
    run("neg1_sgn",  16'hFFFF, 16'h0001, 1'b1, 3'b001, 1);
    run("late",      16'h12F0, 16'h12E0, 1'b0, 3'b010, 3);
    run("late_lt",   16'h12E0, 16'h12F0, 1'b0, 3'b001, 3);

    // Start pulse during RUN must not disturb the compare in flight.
    @(negedge clk); #1;
    expect_res("ign", 3'b001, 4);
    go(16'h0001, 16'h0002, 1'b0);
    go(16'hFFFF, 16'h0000, 1'b1);
    drain("ign");

    // Back-to-back: second start issued in the done cycle of the first.
    @(negedge clk); #1;
    expect_res("b2b1", 3'b001, 4);
    go(16'h1234, 16'h1235, 1'b0);
    n = 0;
    while (!done_ee && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check("b2b_done_seen", 32'(done_ee), 32'd1);
    expect_res("b2b2", 3'b100, 4);
    go(16'h0000, 16'h0000, 1'b0);
    check("b2b_busy_ee", 32'(busy_ee), 32'd1);
    check("b2b_busy_ct", 32'(busy_ct), 32'd1);
    @(negedge clk); #1;
    check("b2b_hold_ee", 32'({ye_ee, yg_ee, yl_ee, cnt_ee}), 32'({3'b001, 3'd4}));
    check("b2b_hold_ct", 32'({ye_ct, yg_ct, yl_ct, cnt_ct}), 32'({3'b001, 3'd4}));
    drain("b2b");

    // Asynchronous reset two cycles into an equal compare.
    @(negedge clk); #1;
    go(16'h1234, 16'h1234, 1'b0);
    @(negedge clk); #1;
    check("pre_rst_busy", 32'({busy_ee, busy_ct}), 32'b11);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ee", 32'({busy_ee, done_ee, ye_ee, yg_ee, yl_ee, cnt_ee}), 32'd0);
    check("rst_mid_ct", 32'({busy_ct, done_ct, ye_ct, yg_ct, yl_ct, cnt_ct}), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("rst_idle_ee", 32'({busy_ee, done_ee, ye_ee, yg_ee, yl_ee, cnt_ee}), 32'd0);
    check("rst_idle_ct", 32'({busy_ct, done_ct, ye_ct, yg_ct, yl_ct, cnt_ct}), 32'd0);

    run("post_rst",  16'h0000, 16'hFFFF, 1'b0, 3'b001, 1);
    run("post_rst_s", 16'h0000, 16'hFFFF, 1'b1, 3'b010, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
